// File: rtl/main_memory_responder_pkg.sv
// Types and constants shared by the main-memory responder and the cache controller.
package mem_pkg;
  localparam int MEM_LAT_W = 4;
  localparam logic MEM_RD = 1'b1;
  localparam logic MEM_WR = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } mem_state_t;
endpackage

// File: rtl/main_memory_responder_if.sv
// Cache-controller <-> main-memory request/response bundle.
interface main_memory_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              Req;
  logic              R_W;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] Wdata;
  logic              PNDNG;
  logic [DATA_W-1:0] Rdata;
  logic              Busy;

  modport master (output Req, R_W, Addr, Wdata, input PNDNG, Rdata, Busy);
  modport slave  (input Req, R_W, Addr, Wdata, output PNDNG, Rdata, Busy);
endinterface

// File: rtl/main_memory_responder_mem_array.sv
// Synchronous single-port RAM: one write or one read per edge, read data registered.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/main_memory_responder.sv
// Main-memory responder: one request at a time, LATENCY-cycle access, one-cycle PNDNG ack.
// Optional MAIN_MEM_STATS_EN adds saturating read/write access counters.
module main_memory_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 4
) (
  input logic CLK,
  input logic RST,
  main_memory_responder_if.slave bus
`ifdef MAIN_MEM_STATS_EN
  ,
  output logic [15:0] Rd_Count,
  output logic [15:0] Wr_Count
`endif
);
  localparam logic [MEM_LAT_W-1:0] LAT_LOAD = MEM_LAT_W'(LATENCY - 1);

  mem_state_t            state_q, state_d;
  logic [MEM_LAT_W-1:0]  cnt_q, cnt_d;
  logic                  rw_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  capture, access;
  logic                  we, re;
  logic [DATA_W-1:0]     rdata;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter exits at zero, so the decrement can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Req) begin
          state_d = WAIT;
          cnt_d   = LAT_LOAD;
          capture = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = RELEASE;
      RELEASE: if (!bus.Req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.PNDNG = (state_q == RESP);
    bus.Busy  = (state_q != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rw_q    <= MEM_WR;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      rw_q    <= bus.R_W;
      addr_q  <= bus.Addr;
      wdata_q <= bus.Wdata;
    end
  end

  assign we = access && (rw_q == MEM_WR);
  assign re = access && (rw_q == MEM_RD);

  mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem_array (
    .clk_i   (CLK),
    .rst_i   (RST),
    .we_i    (we),
    .re_i    (re),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );

  assign bus.Rdata = rdata;

`ifdef MAIN_MEM_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (re && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (we && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 1'b1;
    end
  end

  assign Rd_Count = rd_cnt_q;
  assign Wr_Count = wr_cnt_q;
`endif
endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder at LATENCY=4 and LATENCY=1; MAIN_MEM_STATS_EN also checks the counters.
module tb_main_memory_responder;
  import mem_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  main_memory_responder_if #(.ADDR_W(8), .DATA_W(32)) bus4 ();
  main_memory_responder_if #(.ADDR_W(8), .DATA_W(32)) bus1 ();

  logic        req_v   [2];
  logic        rw_v    [2];
  logic [7:0]  addr_v  [2];
  logic [31:0] wdata_v [2];
  logic        pndng_v [2];
  logic        busy_v  [2];
  logic [31:0] rdata_v [2];

  assign bus4.Req = req_v[0];  assign bus4.R_W = rw_v[0];
  assign bus4.Addr = addr_v[0]; assign bus4.Wdata = wdata_v[0];
  assign bus1.Req = req_v[1];  assign bus1.R_W = rw_v[1];
  assign bus1.Addr = addr_v[1]; assign bus1.Wdata = wdata_v[1];
  assign pndng_v[0] = bus4.PNDNG; assign busy_v[0] = bus4.Busy; assign rdata_v[0] = bus4.Rdata;
  assign pndng_v[1] = bus1.PNDNG; assign busy_v[1] = bus1.Busy; assign rdata_v[1] = bus1.Rdata;

`ifdef MAIN_MEM_STATS_EN
  logic [15:0] rdc_v [2];
  logic [15:0] wrc_v [2];
`endif

  main_memory_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(4)) dut4 (
    .CLK(CLK), .RST(RST), .bus(bus4)
`ifdef MAIN_MEM_STATS_EN
    , .Rd_Count(rdc_v[0]), .Wr_Count(wrc_v[0])
`endif
  );

  main_memory_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(1)) dut1 (
    .CLK(CLK), .RST(RST), .bus(bus1)
`ifdef MAIN_MEM_STATS_EN
    , .Rd_Count(rdc_v[1]), .Wr_Count(wrc_v[1])
`endif
  );

  // Reference model: word-level memory image plus the last completed read.
  int          vectors = 0;
  int          errors  = 0;
  int          LAT [2] = '{4, 1};
  logic [31:0] mem_ref [2][256];
  bit          known   [2][256];
  logic [31:0] rdata_ref   [2];
  bit          rdata_known [2];
  int          rd_n [2];
  int          wr_n [2];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      rdata_ref[s] = '0; rdata_known[s] = 1'b1; rd_n[s] = 0; wr_n[s] = 0;
    end
  endtask

  task automatic check_stats(int s);
`ifdef MAIN_MEM_STATS_EN
    check("rd_count", 32'(rdc_v[s]), 32'(rd_n[s]));
    check("wr_count", 32'(wrc_v[s]), 32'(wr_n[s]));
`endif
  endtask

  // One request: Req held through capture edge and h further edges, inputs altered after capture.
  task automatic run_req(int s, logic rw, logic [7:0] a, logic [31:0] d, int h,
                         logic [7:0] sa, logic [31:0] sd);
    int lat;
    int fin;
    int pulses;
    lat    = LAT[s];
    fin    = (lat + 2 > h + 1) ? lat + 2 : h + 1;
    pulses = 0;
    @(negedge CLK);
    req_v[s] = 1'b1; rw_v[s] = rw; addr_v[s] = a; wdata_v[s] = d;
    @(posedge CLK); #1;
    check("busy_at_capture", 32'(busy_v[s]), 32'd1);
    for (int j = 1; j <= fin; j++) begin
      @(negedge CLK);
      req_v[s] = (j <= h);
      if (j == 1) begin
        rw_v[s] = ~rw; addr_v[s] = sa; wdata_v[s] = sd;
      end
      @(posedge CLK); #1;
      if (j == lat) begin
        if (rw == MEM_WR) begin
          mem_ref[s][a] = d; known[s][a] = 1'b1;
          wr_n[s] = (wr_n[s] >= 65535) ? 65535 : wr_n[s] + 1;
        end else begin
          rdata_ref[s] = mem_ref[s][a]; rdata_known[s] = known[s][a];
          rd_n[s] = (rd_n[s] >= 65535) ? 65535 : rd_n[s] + 1;
        end
      end
      if (pndng_v[s] === 1'b1) pulses++;
      check("pndng_timing", 32'(pndng_v[s]), 32'(j == lat));
      check("busy_timing", 32'(busy_v[s]), 32'(j < fin));
      if (rdata_known[s]) check("rdata", rdata_v[s], rdata_ref[s]);
    end
    check("pndng_pulse_count", 32'(pulses), 32'd1);
    check_stats(s);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      req_v[s] = 1'b0; rw_v[s] = MEM_RD; addr_v[s] = '0; wdata_v[s] = '0;
      for (int i = 0; i < 256; i++) begin
        known[s][i] = 1'b0; mem_ref[s][i] = '0;
      end
    end
    model_reset();
    @(negedge CLK); @(negedge CLK);
    for (int s = 0; s < 2; s++) begin
      check("reset_pndng", 32'(pndng_v[s]), 32'd0);
      check("reset_busy", 32'(busy_v[s]), 32'd0);
      check("reset_rdata", rdata_v[s], 32'd0);
    end
    RST = 1'b0;

    // Write then read 0x12; read dropped in its PNDNG cycle, then held for 20 cycles.
    run_req(0, MEM_WR, 8'h12, 32'hDEADBEEF, 0, 8'h13, 32'h0);
    run_req(0, MEM_RD, 8'h12, 32'h0, 4, 8'h44, 32'h55);
    run_req(0, MEM_RD, 8'h12, 32'h0, 20, 8'h06, 32'h77);

    // Address/data changed during WAIT must not reach the array.
    run_req(0, MEM_WR, 8'h06, 32'hAAAA5555, 0, 8'h07, 32'h9);
    run_req(0, MEM_WR, 8'h05, 32'h1, 1, 8'h06, 32'h2);
    run_req(0, MEM_RD, 8'h05, 32'h0, 0, 8'h06, 32'h0);
    run_req(0, MEM_RD, 8'h06, 32'h0, 0, 8'h05, 32'h0);
    run_req(0, MEM_RD, 8'h12, 32'h0, 0, 8'h05, 32'h0);

    // Reset mid-WAIT of a write to 0x12: uncommitted write is lost.
    @(negedge CLK);
    req_v[0] = 1'b1; rw_v[0] = MEM_WR; addr_v[0] = 8'h12; wdata_v[0] = 32'h0BADF00D;
    @(posedge CLK); #1;
    @(negedge CLK); req_v[0] = 1'b0;
    @(posedge CLK); #1;
    check("busy_before_reset", 32'(busy_v[0]), 32'd1);
    #2 RST = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      check("async_reset_pndng", 32'(pndng_v[s]), 32'd0);
      check("async_reset_busy", 32'(busy_v[s]), 32'd0);
      check("async_reset_rdata", rdata_v[s], 32'd0);
    end
    @(negedge CLK); RST = 1'b0;
    model_reset();
    run_req(0, MEM_RD, 8'h12, 32'h0, 0, 8'h13, 32'h0);

    // LATENCY=1 back-to-back with Req dropped in each PNDNG cycle.
    run_req(1, MEM_WR, 8'h00, 32'h12345678, 1, 8'h01, 32'h0);
    run_req(1, MEM_RD, 8'h00, 32'h0, 1, 8'h01, 32'h0);
    run_req(1, MEM_RD, 8'h00, 32'h0, 1, 8'h02, 32'h0);

    for (int n = 0; n < 40; n++) begin
      int s;
      s = $urandom_range(0, 1);
      run_req(s, logic'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, LAT[s] + 4), 8'($urandom_range(0, 15)), $urandom);
    end

`ifdef MAIN_MEM_STATS_EN
    @(negedge CLK);
    force dut4.rd_cnt_q = 16'hFFFF;
    @(negedge CLK);
    release dut4.rd_cnt_q;
    rd_n[0] = 65535;
    run_req(0, MEM_RD, 8'h12, 32'h0, 0, 8'h13, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
